// File: rtl/mem_pkg.sv
// Shared widths and types for the memory subsystem banks.
package mem_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 8;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

endpackage : mem_pkg

// File: rtl/bank_valid_array.sv
// Per-word "written since reset" flags: cleared as a block, set per write.
module bank_valid_array #(
  parameter int unsigned ADDR_W = mem_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic              set,
  output logic              valid_c
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0] bits;

  // Clear every flag on reset; mark the addressed word on a write.
  always_ff @(posedge clk) begin
    if (reset) begin
      bits <= '0;
    end else if (set) begin
      bits[addr] <= 1'b1;
    end
  end

  // Combinational lookup of the addressed word's flag.
  always_comb begin
    valid_c = bits[addr];
  end

endmodule : bank_valid_array

// File: rtl/bank.sv
// Single-port memory bank with synchronous read and per-word valid tracking.
module bank
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W = mem_pkg::ADDR_W,
  parameter int unsigned DATA_W = mem_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              read_enable,
  input  logic              write_enable,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              word_valid_c;
  logic              do_write_c;

  // Requests in a reset cycle are ignored; enables gate any X on addr.
  always_comb begin
    do_write_c = write_enable & ~reset;
  end

  bank_valid_array #(
    .ADDR_W (ADDR_W)
  ) u_valid (
    .clk     (clk),
    .reset   (reset),
    .addr    (addr),
    .set     (do_write_c),
    .valid_c (word_valid_c)
  );

  // Storage array; deliberately not reset so it maps onto a RAM macro.
  always_ff @(posedge clk) begin
    if (do_write_c) begin
      mem[addr] <= data_in;
    end
  end

  // Registered read: pre-write contents on a same-address read+write,
  // zero data for unwritten words, data held when idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out  <= '0;
      valid_out <= 1'b0;
    end else if (read_enable) begin
      valid_out <= word_valid_c;
      data_out  <= word_valid_c ? mem[addr] : DATA_W'(0);
    end else begin
      valid_out <= 1'b0;
    end
  end

endmodule : bank

// File: tb/tb_bank.sv
// Randomised self-checking bench for bank against a behavioural model.
module tb_bank;
  import mem_pkg::*;

  logic  clk;
  logic  reset;
  addr_t addr;
  data_t data_in;
  logic  read_enable;
  logic  write_enable;
  data_t data_out;
  logic  valid_out;

  bank dut (
    .clk          (clk),
    .reset        (reset),
    .addr         (addr),
    .data_in      (data_in),
    .read_enable  (read_enable),
    .write_enable (write_enable),
    .data_out     (data_out),
    .valid_out    (valid_out)
  );

  always #5 clk = ~clk;

  // Reference model: contents, written-since-reset flags, expected outputs.
  data_t ref_mem   [256];
  bit    ref_valid [256];
  data_t exp_data;
  bit    exp_valid;

  int n_cmp;
  int n_err;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of stimulus, advance the model, compare both outputs.
  task automatic do_cycle(input bit rst, input bit re, input bit we,
                          input addr_t a, input data_t d, input string tag);
    reset        = rst;
    read_enable  = re;
    write_enable = we;
    addr         = a;
    data_in      = d;
    @(posedge clk);
    #1;
    if (rst) begin
      for (int i = 0; i < 256; i++) ref_valid[i] = 1'b0;
      exp_data  = '0;
      exp_valid = 1'b0;
    end else begin
      if (re) begin
        exp_valid = ref_valid[int'(a)];
        exp_data  = exp_valid ? ref_mem[int'(a)] : data_t'(0);
      end else begin
        exp_valid = 1'b0;
      end
      if (we) begin
        ref_mem[int'(a)]   = d;
        ref_valid[int'(a)] = 1'b1;
      end
    end
    check_eq({tag, "_data"},  32'(data_out),  32'(exp_data));
    check_eq({tag, "_valid"}, 32'(valid_out), 32'(exp_valid));
  endtask

  initial begin
    clk = 1'b0;
    n_cmp = 0;
    n_err = 0;
    exp_data = '0;
    exp_valid = 1'b0;
    for (int i = 0; i < 256; i++) begin
      ref_mem[i]   = '0;
      ref_valid[i] = 1'b0;
    end
    #2;

    // Reset, then read of address 0.
    do_cycle(1, 1, 1, 8'd0, 8'd99, "reset");
    do_cycle(0, 1, 0, 8'd0, 8'd0, "rd0_after_reset");
    check_eq("tp_rd0_valid", 32'(valid_out), 32'd0);
    check_eq("tp_rd0_data",  32'(data_out),  32'd0);

    // Write 24 to address 9, then read it.
    do_cycle(0, 0, 1, 8'd9, 8'd24, "wr9");
    do_cycle(0, 1, 0, 8'd9, 8'd0, "rd9");
    check_eq("tp_rd9_data", 32'(data_out), 32'd24);

    // Top address and its unwritten neighbour.
    do_cycle(0, 0, 1, 8'd255, 8'd145, "wr255");
    do_cycle(0, 1, 0, 8'd255, 8'd0, "rd255");
    check_eq("tp_rd255_data", 32'(data_out), 32'd145);
    do_cycle(0, 1, 0, 8'd254, 8'd0, "rd254");
    check_eq("tp_rd254_valid", 32'(valid_out), 32'd0);

    // Same-address read and write returns the old word.
    do_cycle(0, 1, 1, 8'd9, 8'd77, "rw9");
    check_eq("tp_rw9_data", 32'(data_out), 32'd24);
    do_cycle(0, 1, 0, 8'd9, 8'd0, "rd9_new");
    check_eq("tp_rd9_new_data", 32'(data_out), 32'd77);

    // Reset mid-operation invalidates, rewrite revalidates.
    do_cycle(0, 0, 1, 8'd9, 8'd33, "wr9_pre_reset");
    do_cycle(1, 0, 0, 8'd9, 8'd0, "mid_reset");
    do_cycle(0, 1, 0, 8'd9, 8'd0, "rd9_post_reset");
    check_eq("tp_rd9_post_reset_data", 32'(data_out), 32'd0);
    do_cycle(0, 0, 1, 8'd9, 8'd5, "wr9_5");
    do_cycle(0, 1, 0, 8'd9, 8'd0, "rd9_5");
    check_eq("tp_rd9_5_data", 32'(data_out), 32'd5);

    // Idle cycle drops valid, holds data; X address while idle is harmless.
    do_cycle(0, 0, 0, 8'd9, 8'd0, "idle_hold");
    check_eq("tp_idle_data", 32'(data_out), 32'd5);
    do_cycle(0, 0, 0, 8'bxxxx_xxxx, 8'bxxxx_xxxx, "idle_x");
    do_cycle(0, 1, 0, 8'd254, 8'd0, "rd254_after_x");
    do_cycle(0, 1, 0, 8'd9, 8'd0, "rd9_after_x");

    // Random traffic, biased to a small address window to revisit words.
    for (int it = 0; it < 3000; it++) begin
      bit    rst, re, we;
      addr_t a;
      data_t d;
      rst = ($urandom_range(0, 149) == 0);
      re  = 1'($urandom);
      we  = 1'($urandom);
      case ($urandom_range(0, 3))
        0:       a = addr_t'($urandom);
        1:       a = addr_t'(8'd255 - 8'($urandom_range(0, 3)));
        default: a = addr_t'($urandom_range(0, 15));
      endcase
      d = data_t'($urandom);
      do_cycle(rst, re, we, a, d, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_bank
